apb_slave: RTL and testbench
============================

# apb_slave

APB responder that terminates the transfers issued by the team's APB master and fronts a small on-chip register file. It decodes psel/penable/pwrite, inserts a fixed number of wait states, and completes each transfer with pready. Out-of-range addresses complete with pslverr. It sits on the peripheral side of the 8-bit APB bus, one instance per peripheral select.

## Interface
Parameters:
- ADDR_W, 8: paddr width.
- DATA_W, 8: pwdata/prdata width.
- DEPTH, 64: number of implemented registers, at addresses 0..DEPTH-1; DEPTH <= 2**ADDR_W.
- WAIT_CYCLES, 0: wait states inserted in every ACCESS phase, 0..15.

Ports (one clock; reset is synchronous and active-high):
- pclk  in  1  bus clock; all state changes on its rising edge.
- preset  in  1  synchronous, active-high reset.
- psel  in  1  slave select from the master.
- penable  in  1  access-phase strobe.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_W  transfer address.
- pwdata  in  DATA_W  write data.
- prdata  out  DATA_W  read data; valid only while pready=1 on a read.
- pready  out  1  transfer completes in the cycle it is 1.
- pslverr  out  1  error response; valid only while pready=1.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: psel=1 && penable=0 -> SETUP. Any other input (including penable=1 without a preceding setup) -> stay in IDLE, no response.
- SETUP (first cycle with psel=1): latch paddr -> addr_q, pwrite -> write_q, pwdata -> wdata_q; load wait counter with WAIT_CYCLES; go to ACCESS unconditionally.
- ACCESS: if psel=0, abort and go to IDLE with no write. Otherwise, if counter != 0, decrement it and hold pready=0. When counter == 0, drive pready=1, then:
  - psel=1 && penable=0 on the next cycle -> SETUP (back-to-back transfer);
  - otherwise -> IDLE.
- Commit: write happens at the rising edge that ends the pready=1 cycle, only when write_q=1 and addr_q < DEPTH.
- Read: prdata = regfile[addr_q] when pready=1 and write_q=0 and addr_q < DEPTH; otherwise prdata = 0.
- Error: pslverr = 1 only when pready=1 and addr_q >= DEPTH. Erroring writes do not modify storage. Erroring reads return 0.
- Address and data changes on the bus during ACCESS are ignored; the latched values are used.
- pready, pslverr and prdata decode combinationally from registered state, counter and addr_q. They have no combinational path from bus inputs, except the psel abort.

## Timing
- Reset values: state IDLE, counter 0, pready 0, pslverr 0, prdata 0, addr_q/write_q/wdata_q 0, all registers 0.
- Reset mid-transfer: next cycle is IDLE with all outputs 0, and any pending write is dropped.
- Latency: setup at cycle T. With WAIT_CYCLES=0, pready=1 at T+1. With WAIT_CYCLES=N, pready=1 at T+1+N. pready stays high for exactly one cycle.
- Back-to-back: a new setup can start in the cycle immediately after pready, giving one transfer every 2+N cycles.
- Read-after-write to the same address: the read setup follows the write's pready cycle, so the read returns the new data.

## Structure
- Shared package apb_pkg holds:
  - the state enum (IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10), also used by the master;
  - ADDR_W/DATA_W defaults.
- Sub-module apb_regfile holds the DEPTH x DATA_W array, with:
  - synchronous write enable;
  - combinational read port;
  - synchronous clear on preset.
- The FSM, wait counter and response decode stay in apb_slave.

## Test plan
- Write then read, WAIT_CYCLES=0: write 8'hA5 to 8'h03, then read 8'h03 -> pready at T+1 each time; read gives prdata=8'hA5, pslverr=0.
- Wait states, WAIT_CYCLES=3: read of 8'h10 -> pready low for 3 ACCESS cycles, high at T+4 for one cycle.
- Error, DEPTH=64: write 8'hFF to 8'h40 -> pslverr=1 with pready. A following read of 8'h40 gives prdata=0, pslverr=1. A read of 8'h00 is unchanged.
- Abort: psel drops after setup of a write of 8'h55 to 8'h05 -> FSM returns to IDLE, pready never asserts, and a read of 8'h05 returns the old value.
- Reset mid-access: preset=1 during ACCESS with WAIT_CYCLES=2 -> next cycle pready=0, pslverr=0, prdata=0, all registers read back 0.
- Back-to-back with bus noise: writes to 8'h01, 8'h02 and 8'h03 with no IDLE gap, paddr changed during ACCESS -> each transfer completes every 2 cycles and the data lands at the latched addresses.

Source files
------------

// File: rtl/apb_pkg.sv
// apb_pkg: definitions shared by the APB master and slave.
//   - bus width defaults for paddr and pwdata/prdata
//   - FSM state encodings, as localparam constants for legacy code and as
//     an enum type for new code; both carry the same values
package apb_pkg;

    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 8;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_SETUP  = 2'b01;
    localparam logic [1:0] ST_ACCESS = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        SETUP  = ST_SETUP,
        ACCESS = ST_ACCESS
    } apb_state_e;

    // Largest wait-state count the 4-bit wait counter can hold.
    localparam int APB_MAX_WAIT = 15;

endpackage

// File: rtl/apb_regfile.sv
// apb_regfile: DEPTH x DATA_W register array behind the APB slave.
//   clk    in   clock; writes and clear happen on its rising edge
//   rst    in   synchronous active-high clear of every register
//   we     in   write enable (ignored for addresses >= DEPTH)
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   combinational read address
//   rdata  out  contents at raddr, 0 for addresses >= DEPTH
module apb_regfile
    import apb_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic waddr_ok;
    logic raddr_ok;

    assign waddr_ok = ({1'b0, waddr} < DEPTH_L);
    assign raddr_ok = ({1'b0, raddr} < DEPTH_L);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we && waddr_ok) begin
            mem[waddr[IDX_W-1:0]] <= wdata;
        end
    end

    always_comb begin
        rdata = '0;
        if (raddr_ok) begin
            rdata = mem[raddr[IDX_W-1:0]];
        end
    end

endmodule

// File: rtl/apb_slave.sv
// apb_slave: APB responder fronting an apb_regfile.
//   pclk     in   bus clock
//   preset   in   synchronous active-high reset
//   psel     in   slave select
//   penable  in   access-phase strobe
//   pwrite   in   1 = write, 0 = read
//   paddr    in   transfer address
//   pwdata   in   write data
//   prdata   out  read data, non-zero only on a successful read with pready
//   pready   out  transfer completes in the cycle this is 1
//   pslverr  out  error response for addresses >= DEPTH, only with pready
// Every ACCESS phase is stretched by WAIT_CYCLES wait states.
module apb_slave
    import apb_pkg::*;
#(
    parameter int ADDR_W      = APB_ADDR_W,
    parameter int DATA_W      = APB_DATA_W,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr
);

    localparam logic [3:0]      WAIT_INIT = 4'(WAIT_CYCLES);
    localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W + 1)'(DEPTH);

    logic [1:0]        state;
    logic [1:0]        phase;
    logic [1:0]        state_nxt;
    logic [3:0]        cnt;
    logic [3:0]        cnt_nxt;
    logic              load;

    logic [ADDR_W-1:0] addr_q;
    logic              write_q;
    logic [DATA_W-1:0] wdata_q;

    logic              in_range;
    logic              reg_we;
    logic [DATA_W-1:0] reg_rdata;

    // The setup cycle is the bus cycle with psel=1, penable=0 seen while
    // idle; it is decoded here rather than registered so that the request
    // is latched at the edge closing that cycle and pready can rise in the
    // very next cycle. The state register therefore only ever holds
    // IDLE or ACCESS.
    always_comb begin
        phase = state;
        if (state == ST_IDLE && psel && !penable) begin
            phase = ST_SETUP;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load      = 1'b0;
        case (phase)
            ST_IDLE: begin
                state_nxt = ST_IDLE;
            end
            ST_SETUP: begin
                state_nxt = ST_ACCESS;
                cnt_nxt   = WAIT_INIT;
                load      = 1'b1;
            end
            ST_ACCESS: begin
                if (!psel) begin
                    state_nxt = ST_IDLE;
                end else if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    // Completion cycle; a back-to-back setup is picked up
                    // from IDLE in the following cycle.
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (load) begin
                addr_q  <= paddr;
                write_q <= pwrite;
                wdata_q <= pwdata;
            end
        end
    end

    assign in_range = ({1'b0, addr_q} < DEPTH_L);

    // psel gates pready so that dropping select in ACCESS aborts the
    // transfer without a response or a commit.
    assign pready  = (state == ST_ACCESS) && (cnt == 4'd0) && psel;
    assign pslverr = pready && !in_range;
    assign reg_we  = pready && write_q && in_range;

    always_comb begin
        prdata = '0;
        if (pready && !write_q && in_range) begin
            prdata = reg_rdata;
        end
    end

    apb_regfile #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_regfile (
        .clk   (pclk),
        .rst   (preset),
        .we    (reg_we),
        .waddr (addr_q),
        .wdata (wdata_q),
        .raddr (addr_q),
        .rdata (reg_rdata)
    );

endmodule

// File: tb/tb_apb_slave.sv
// tb_apb_slave: self-checking bench for apb_slave. Two instances share the
// bus (separate selects): u_dut0 with no wait states and u_dut3 with three.
module tb_apb_slave;

    localparam int DEPTH = 64;

    logic       pclk = 1'b0;
    logic       preset;
    logic [1:0] psel;
    logic       penable;
    logic       pwrite;
    logic [7:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] prdata0;
    logic [7:0] prdata1;
    logic [1:0] pready;
    logic [1:0] pslverr;

    int checks = 0;
    int errors = 0;

    // Reference storage: what each instance's registers should hold.
    logic [7:0] model [2][256];

    always #5 pclk = ~pclk;

    apb_slave #(
        .ADDR_W      (8),
        .DATA_W      (8),
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (0)
    ) u_dut0 (
        .pclk    (pclk),
        .preset  (preset),
        .psel    (psel[0]),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata0),
        .pready  (pready[0]),
        .pslverr (pslverr[0])
    );

    apb_slave #(
        .ADDR_W      (8),
        .DATA_W      (8),
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (3)
    ) u_dut3 (
        .pclk    (pclk),
        .preset  (preset),
        .psel    (psel[1]),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata1),
        .pready  (pready[1]),
        .pslverr (pslverr[1])
    );

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] exp_rd;
        logic       exp_err;
    } vec_t;

    vec_t vecs [5];

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] rd_of(input int s);
        return (s == 1) ? prdata1 : prdata0;
    endfunction

    function automatic void clear_models();
        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 256; a++)
                model[s][a] = 8'h00;
    endfunction

    // One complete transfer on instance s, starting with its setup cycle in
    // the cycle after the call. Returns at the falling edge of the pready
    // cycle so a following call runs back-to-back.
    task automatic xfer(input int s, input logic wr, input logic [7:0] a,
                        input logic [7:0] d, input bit noise,
                        output logic [7:0] rd, output logic err);
        int         lat;
        bit         done;
        logic [7:0] exp_rd;
        logic       exp_err;
        int         exp_lat;
        exp_err = (a >= DEPTH);
        exp_rd  = (!wr && !exp_err) ? model[s][a] : 8'h00;
        exp_lat = (s == 1) ? 4 : 1;
        rd      = 8'h00;
        err     = 1'b0;

        @(posedge pclk); #1;
        psel    = 2'b00;
        psel[s] = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a;
        pwdata  = d;
        @(negedge pclk);
        check1("setup_pready", pready[s], 1'b0);

        @(posedge pclk); #1;
        penable = 1'b1;
        if (noise) begin
            paddr  = 8'($urandom);
            pwdata = 8'($urandom);
            pwrite = ~wr;
        end
        lat  = 0;
        done = 0;
        while (!done && lat < 20) begin
            @(negedge pclk);
            lat++;
            if (pready[s]) begin
                done = 1;
            end else begin
                @(posedge pclk); #1;
                if (noise) paddr = 8'($urandom);
            end
        end

        check1("ready_seen", done, 1'b1);
        if (done) begin
            rd  = rd_of(s);
            err = pslverr[s];
            check_int("latency", lat, exp_lat);
            check8("prdata", rd, exp_rd);
            check1("pslverr", err, exp_err);
            check1("other_quiet", pready[1-s], 1'b0);
            if (wr && !exp_err) model[s][a] = d;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge pclk); #1;
            psel    = 2'b00;
            penable = 1'b0;
            @(negedge pclk);
            check8("idle_pready", {6'd0, pready}, 8'h00);
        end
    endtask

    initial begin
        logic [7:0] rd;
        logic       err;

        vecs[0] = '{1'b1, 8'h03, 8'hA5, 8'h00, 1'b0};
        vecs[1] = '{1'b0, 8'h03, 8'h00, 8'hA5, 1'b0};
        vecs[2] = '{1'b1, 8'h40, 8'hFF, 8'h00, 1'b1};
        vecs[3] = '{1'b0, 8'h40, 8'h00, 8'h00, 1'b1};
        vecs[4] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0};

        preset  = 1'b1;
        psel    = 2'b00;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 8'h00;
        pwdata  = 8'h00;
        clear_models();
        repeat (2) @(posedge pclk);
        #1 preset = 1'b0;
        @(negedge pclk);
        check8("reset_pready", {6'd0, pready}, 8'h00);
        check8("reset_pslverr", {6'd0, pslverr}, 8'h00);
        check8("reset_prdata0", prdata0, 8'h00);
        check8("reset_prdata1", prdata1, 8'h00);

        // Directed table on the zero-wait instance.
        for (int i = 0; i < 5; i++) begin
            xfer(0, vecs[i].wr, vecs[i].addr, vecs[i].data, 1'b0, rd, err);
            check8("vec_rd", rd, vecs[i].exp_rd);
            check1("vec_err", err, vecs[i].exp_err);
            idle(1);
        end

        // Wait states: read of 0x10 completes four cycles after setup.
        xfer(1, 1'b1, 8'h10, 8'h3C, 1'b0, rd, err);
        idle(1);
        xfer(1, 1'b0, 8'h10, 8'h00, 1'b0, rd, err);
        check8("wait_read", rd, 8'h3C);
        idle(2);

        // Abort: select drops after setup, the old value survives.
        xfer(0, 1'b1, 8'h05, 8'h11, 1'b0, rd, err);
        idle(1);
        @(posedge pclk); #1;
        psel    = 2'b01;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 8'h05;
        pwdata  = 8'h55;
        @(posedge pclk); #1;
        psel    = 2'b00;
        penable = 1'b1;
        @(negedge pclk);
        check1("abort_pready", pready[0], 1'b0);
        idle(3);
        xfer(0, 1'b0, 8'h05, 8'h00, 1'b0, rd, err);
        check8("abort_keep", rd, 8'h11);
        idle(1);

        // Back-to-back writes with address/data noise during ACCESS.
        xfer(0, 1'b1, 8'h01, 8'hA1, 1'b1, rd, err);
        xfer(0, 1'b1, 8'h02, 8'hB2, 1'b1, rd, err);
        xfer(0, 1'b1, 8'h03, 8'hC3, 1'b1, rd, err);
        xfer(0, 1'b0, 8'h01, 8'h00, 1'b0, rd, err);
        check8("b2b_r1", rd, 8'hA1);
        xfer(0, 1'b0, 8'h02, 8'h00, 1'b0, rd, err);
        check8("b2b_r2", rd, 8'hB2);
        xfer(0, 1'b0, 8'h03, 8'h00, 1'b0, rd, err);
        check8("b2b_r3", rd, 8'hC3);
        idle(1);

        // Randomized traffic against the reference storage.
        for (int n = 0; n < 300; n++) begin
            int         s;
            logic       wr;
            logic [7:0] a;
            s  = int'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            a  = 8'($urandom_range(0, 79));
            xfer(s, wr, a, 8'($urandom), bit'($urandom_range(0, 1)), rd, err);
            if ($urandom_range(0, 2) == 0) idle(1);
        end
        idle(1);

        // Reset in the middle of a wait-stated write.
        xfer(1, 1'b1, 8'h07, 8'h77, 1'b0, rd, err);
        idle(1);
        @(posedge pclk); #1;
        psel    = 2'b10;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 8'h07;
        pwdata  = 8'hEE;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        preset  = 1'b1;
        @(posedge pclk); #1;
        preset  = 1'b0;
        clear_models();
        @(negedge pclk);
        check1("rst_mid_pready", pready[1], 1'b0);
        check1("rst_mid_pslverr", pslverr[1], 1'b0);
        check8("rst_mid_prdata", prdata1, 8'h00);
        idle(1);
        for (int a = 0; a < DEPTH; a++) begin
            xfer(1, 1'b0, 8'(a), 8'h00, 1'b0, rd, err);
        end
        for (int a = 0; a < 8; a++) begin
            xfer(0, 1'b0, 8'(a), 8'h00, 1'b0, rd, err);
        end
        idle(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
